// File: rtl/ahb_arbiter_if.sv
// Arbiter-side AHB-Lite signal bundle: requests, transfer state, grant.
// Lock signals exist only when AHB_ARB_LOCK_EN is defined.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [1:0]             HTRANS;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [1:0]             HMASTER;
  logic [1:0]             HMASTER_DATA;
`ifdef AHB_ARB_LOCK_EN
  logic [NUM_MASTERS-1:0] HLOCK;
  logic                   HMASTLOCK;
`endif

  modport slave (
    input  HBUSREQ,
    input  HTRANS,
    input  HREADY,
`ifdef AHB_ARB_LOCK_EN
    input  HLOCK,
    output HMASTLOCK,
`endif
    output HGRANT,
    output HMASTER,
    output HMASTER_DATA
  );

  modport master (
    output HBUSREQ,
    output HTRANS,
    output HREADY,
`ifdef AHB_ARB_LOCK_EN
    output HLOCK,
    input  HMASTLOCK,
`endif
    input  HGRANT,
    input  HMASTER,
    input  HMASTER_DATA
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter for 2..4 masters with bus parking.
// Optional locked transfers are enabled by defining AHB_ARB_LOCK_EN.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input logic         HCLK,
  input logic         HRESTn,
  ahb_arbiter_if.slave bus
);

  localparam logic [1:0] DEF = 2'(DEFAULT_MASTER);
  localparam logic [2:0] NM  = 3'(NUM_MASTERS);

  typedef enum logic {
    PARK,
    OWN
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_last;
  logic [1:0] w_last_nxt;
  logic [1:0] r_master;
  logic [1:0] w_master_nxt;
  logic [1:0] r_mdata;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_grant_nxt;

  logic [3:0] w_req4;
  logic [2:0] w_sum;
  logic [1:0] w_win;
  logic       w_found;
  logic       w_hold;
  logic       w_ap;

`ifdef AHB_ARB_LOCK_EN
  logic [3:0] w_lock4;
  logic       r_lock;
  logic       w_lock_nxt;
  assign w_lock4 = 4'(bus.HLOCK);
  assign w_hold  = w_lock4[r_master];
`else
  assign w_hold  = 1'b0;
`endif

  assign w_req4 = 4'(bus.HBUSREQ);
  assign w_ap   = bus.HREADY && !w_hold &&
                  (bus.HTRANS == 2'b00 || bus.HTRANS == 2'b10);

  // Scan starts after the last winner, so the last winner is checked last.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_sum   = 3'd0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_sum = {1'b0, r_last} + 3'(i);
      if (w_sum >= NM)
        w_sum = w_sum - NM;
      if (!w_found && w_req4[w_sum[1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_master_nxt = r_master;
    w_last_nxt   = r_last;
    unique case (r_state)
      PARK: begin
        if (w_ap && w_found) begin
          w_state_nxt  = OWN;
          w_master_nxt = w_win;
          w_last_nxt   = w_win;
        end
      end
      OWN: begin
        if (w_ap && w_found) begin
          w_master_nxt = w_win;
          w_last_nxt   = w_win;
        end else if (w_ap) begin
          w_state_nxt  = PARK;
          w_master_nxt = DEF;
        end
      end
      default: w_state_nxt = PARK;
    endcase
    w_grant_nxt = NUM_MASTERS'(4'b0001 << w_master_nxt);
  end

`ifdef AHB_ARB_LOCK_EN
  always_comb begin
    w_lock_nxt = r_lock;
    if (w_ap)
      w_lock_nxt = w_lock4[w_master_nxt];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESTn)
      r_lock <= 1'b0;
    else
      r_lock <= w_lock_nxt;
  end

  assign bus.HMASTLOCK = r_lock;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESTn) begin
      r_state  <= PARK;
      r_last   <= DEF;
      r_master <= DEF;
      r_mdata  <= DEF;
      r_grant  <= NUM_MASTERS'(4'b0001 << DEF);
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_master <= w_master_nxt;
      r_grant  <= w_grant_nxt;
      if (bus.HREADY)
        r_mdata <= r_master;
    end
  end

  assign bus.HGRANT       = r_grant;
  assign bus.HMASTER      = r_master;
  assign bus.HMASTER_DATA = r_mdata;

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin bus arbiter that shares the single AHB-Lite address/data path (decoder, RAM, ROM, response mux) between up to 4 masters.
- Samples per-master bus requests and drives a one-hot grant.
- Drives HMASTER to steer the master-side address/control mux, and HMASTER_DATA (HMASTER delayed by one data phase) to steer the write-data mux.
- Never breaks a burst in progress; parks the bus on a default master when nobody requests.

Parameters:
- NUM_MASTERS, 2, number of requesters; legal range 2..4.
- DEFAULT_MASTER, 0, index granted after reset and when no requests are pending; must be < NUM_MASTERS.

Ports:
- HCLK  in  1  bus clock; all state changes on its rising edge.
- HRESTn  in  1  synchronous active-low reset, sampled on rising edge of HCLK.
- HBUSREQ  in  NUM_MASTERS  per-master bus request, bit i = master i.
- HTRANS  in  2  transfer type of the current bus owner, after the master mux (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HREADY  in  1  bus-level ready from the slave response mux.
- HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  2  index of the current address-phase owner, registered.
- HMASTER_DATA  out  2  index of the current data-phase owner, registered.

Behaviour:
- Reset (HRESTn=0 at an edge):
  - HGRANT = one-hot(DEFAULT_MASTER); HMASTER = HMASTER_DATA = DEFAULT_MASTER.
  - State = PARK; round-robin pointer last = DEFAULT_MASTER.
  - Reset mid-burst aborts immediately, with no completion of the burst.
- States:
  - PARK: DEFAULT_MASTER holds the grant with no request pending.
  - OWN: a requesting master holds the grant.
- Arbitration point (AP): rising edge with HRESTn=1, HREADY=1, and HTRANS in {IDLE, NONSEQ}.
  - HTRANS = SEQ or BUSY, or HREADY = 0 (wait state), is never an AP; the grant is frozen.
- Winner selection at each AP:
  - Scan HBUSREQ starting at (last+1) mod NUM_MASTERS, wrapping around.
  - The current owner is considered last, so a continuous requester cannot starve the others.
  - At NUM_MASTERS-1, the scan wraps to 0.
  - Request bits at index ≥ NUM_MASTERS are ignored.
- At an AP:
  - If any request is present: HGRANT = one-hot(winner), HMASTER = winner, last = winner, state = OWN.
  - If no request is present: HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, state = PARK; last is unchanged.
- Latency: a request present at an AP edge is reflected in HGRANT/HMASTER immediately after that edge (1 cycle from request assertion when already at an AP).
- Owner deasserting HBUSREQ mid-burst: it keeps the bus until the next AP.
- Simultaneous requests: resolved strictly by the round-robin scan order.
- Single requester: re-wins every AP; HGRANT is stable.
- HMASTER_DATA <= HMASTER on every edge with HREADY=1; it holds while HREADY=0.
- HGRANT is always exactly one-hot (never zero, never multi-hot), and HMASTER always equals the index of the HGRANT bit.

Optional Feature:
- Macro: AHB_ARB_LOCK_EN.
- When defined, the following ports are added:
  - HLOCK  in  NUM_MASTERS  per-master lock request.
  - HMASTLOCK  out  1  registered lock indication; reset value 0.
- Lock rules with the macro defined:
  - An AP is suppressed while HLOCK[HMASTER]=1: the owner retains the bus regardless of other requests.
  - HMASTLOCK updates at the same edges as HMASTER, taking the value of HLOCK[winner].
  - Once the owner drops HLOCK, it is re-arbitrated at the next AP.
- When undefined: no HLOCK/HMASTLOCK ports exist and behaviour is exactly as above.

Test Plan:
- Reset: hold HRESTn=0 for 2 cycles with HBUSREQ=11 → HGRANT=01, HMASTER=0, HMASTER_DATA=0 (NUM_MASTERS=2, DEFAULT_MASTER=0).
- Round-robin: NUM_MASTERS=4, HBUSREQ=1111, HTRANS=NONSEQ, HREADY=1 each cycle → HMASTER sequence 1,2,3,0,1 and HGRANT 0010,0100,1000,0001,0010.
- Burst protection: master 1 owns, HTRANS=SEQ for 3 cycles with HBUSREQ=0101 → HGRANT stays 0010; the first IDLE/NONSEQ edge then grants master 2 (HGRANT=0100).
- Wait states: HREADY=0 for 2 cycles during NONSEQ with a new request present → HGRANT and HMASTER_DATA unchanged; HMASTER_DATA takes the new HMASTER one edge after HREADY returns to 1.
- Parking: all HBUSREQ=0 at an AP → HGRANT=one-hot(DEFAULT_MASTER), state PARK. A later single request from master 3 → HMASTER=3 at the next AP.
- Lock (AHB_ARB_LOCK_EN): master 0 owns with HLOCK[0]=1 and HBUSREQ=0011 over 4 APs → HMASTER=0 and HMASTLOCK=1 throughout; after HLOCK[0] drops, the next AP gives HMASTER=1, HMASTLOCK=0.
